// File: rtl/vigna_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_bus_pkg
//  Description : Shared definitions for the vigna bus responder: peripheral
//                region nibble, timer register offsets, per-port FSM state
//                type and a byte-lane merge helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package vigna_bus_pkg;

    // addr[31:28] value that routes an access to the timer peripheral
    localparam logic [3:0] PERIPH_NIBBLE = 4'hF;

    // Peripheral register offsets (addr[7:0] with addr[1:0] forced to zero)
    localparam logic [7:0] MTIME_LO    = 8'h00;
    localparam logic [7:0] MTIME_HI    = 8'h04;
    localparam logic [7:0] MTIMECMP_LO = 8'h08;
    localparam logic [7:0] MTIMECMP_HI = 8'h0C;
    localparam logic [7:0] MSIP        = 8'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } port_state_e;

    // Replace each byte of old_v whose strobe bit is set with the new byte
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_v;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
                res[8*k +: 8] = new_v[8*k +: 8];
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vigna_resp_port.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_resp_port
//  Description : One valid/ready responder port: request latch, latency
//                counter and IDLE/WAIT/RESP sequencer. Emits a one-cycle
//                access enable on the cycle whose closing edge performs the
//                access, and a one-cycle ready in the following cycle.
//  Ports       : clk, resetn            - clock, async active-low reset
//                valid/addr/wdata/wstrb - incoming request
//                ready                  - response strobe
//                access                 - perform access at the next edge
//                req_addr/wdata/wstrb   - request captured at acceptance
//  Revision    : 1.0 - initial release
// ============================================================================
module vigna_resp_port
    import vigna_bus_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        ready,
    output logic        access,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    port_state_e state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    // Next state; the request is only captured in IDLE, so bus activity
    // during WAIT/RESP cannot disturb the pending access
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d = WAIT;
                    cnt_d   = CNT_LOAD;
                    addr_d  = addr;
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        ready  = (state_q == RESP);
        access = (state_q == WAIT) && (cnt_q == 4'd0);
    end

    assign req_addr  = addr_q;
    assign req_wdata = wdata_q;
    assign req_wstrb = wstrb_q;

endmodule
`default_nettype wire

// File: rtl/vigna_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vigna_bus_responder
//  Description : Instruction + data responder for the vigna core. Both ports
//                share one dual-ported word memory; the data port also
//                reaches a machine timer / software interrupt block.
//  Ports       : clk, resetn                   - clock, async active-low reset
//                i_valid/i_addr                - fetch request
//                i_ready/i_rdata               - fetch response
//                d_valid/d_addr/d_wdata/d_wstrb- data request (wstrb==0: read)
//                d_ready/d_rdata               - data response
//                timer_irq/soft_irq            - level interrupts to the core
//  Revision    : 1.0 - initial release
// ============================================================================
module vigna_bus_responder
    import vigna_bus_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic [31:0] i_rdata,
    input  logic        d_valid,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        timer_irq,
    output logic        soft_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];

    // ---------------------------------------------------------------- ports
    logic        i_acc, d_acc;
    logic [31:0] i_req_addr, i_req_wdata, d_req_addr, d_req_wdata;
    logic [3:0]  i_req_wstrb, d_req_wstrb;

    vigna_resp_port #(.LATENCY(LATENCY)) u_iport (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (i_valid),
        .addr      (i_addr),
        .wdata     (32'd0),
        .wstrb     (4'd0),
        .ready     (i_ready),
        .access    (i_acc),
        .req_addr  (i_req_addr),
        .req_wdata (i_req_wdata),
        .req_wstrb (i_req_wstrb)
    );

    vigna_resp_port #(.LATENCY(LATENCY)) u_dport (
        .clk       (clk),
        .resetn    (resetn),
        .valid     (d_valid),
        .addr      (d_addr),
        .wdata     (d_wdata),
        .wstrb     (d_wstrb),
        .ready     (d_ready),
        .access    (d_acc),
        .req_addr  (d_req_addr),
        .req_wdata (d_req_wdata),
        .req_wstrb (d_req_wstrb)
    );

    // Only some address bits participate in decode; the fetch port never writes
    logic unused_bits;
    assign unused_bits = ^{i_req_addr, d_req_addr, i_req_wdata, i_req_wstrb};

    // --------------------------------------------------------------- decode
    logic          i_periph, d_periph, d_is_wr;
    logic [AW-1:0] i_idx, d_idx;
    logic [7:0]    d_off;

    assign i_periph = (i_req_addr[31:28] == PERIPH_NIBBLE);
    assign d_periph = (d_req_addr[31:28] == PERIPH_NIBBLE);
    assign i_idx    = i_req_addr[AW+1:2];
    assign d_idx    = d_req_addr[AW+1:2];
    assign d_off    = {d_req_addr[7:2], 2'b00};
    assign d_is_wr  = (d_req_wstrb != 4'd0);

    // --------------------------------------------------------------- memory
    // Non-blocking write means a same-edge fetch of this word sees old data
    always_ff @(posedge clk) begin
        if (d_acc && d_is_wr && !d_periph) begin
            for (int k = 0; k < 4; k++) begin
                if (d_req_wstrb[k]) begin
                    mem[d_idx][8*k +: 8] <= d_req_wdata[8*k +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------- peripheral
    logic [63:0] mtime_q,    mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q,     msip_d;
    logic        timer_irq_q, timer_irq_d;
    logic        soft_irq_q,  soft_irq_d;
    logic [31:0] periph_rdata;
    logic        per_wr;

    assign per_wr = d_acc && d_is_wr && d_periph;

    always_comb begin
        mtime_d      = mtime_q + 64'd1;
        mtimecmp_d   = mtimecmp_q;
        msip_d       = msip_q;
        periph_rdata = 32'd0;
        case (d_off)
            MTIME_LO:    periph_rdata = mtime_q[31:0];
            MTIME_HI:    periph_rdata = mtime_q[63:32];
            MTIMECMP_LO: periph_rdata = mtimecmp_q[31:0];
            MTIMECMP_HI: periph_rdata = mtimecmp_q[63:32];
            MSIP:        periph_rdata = {31'd0, msip_q};
            default:     periph_rdata = 32'd0;
        endcase
        // A write to either mtime half takes the place of that edge's increment
        if (per_wr) begin
            case (d_off)
                MTIME_LO:    mtime_d = {mtime_q[63:32],
                                        merge_bytes(mtime_q[31:0], d_req_wdata, d_req_wstrb)};
                MTIME_HI:    mtime_d = {merge_bytes(mtime_q[63:32], d_req_wdata, d_req_wstrb),
                                        mtime_q[31:0]};
                MTIMECMP_LO: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], d_req_wdata, d_req_wstrb);
                MTIMECMP_HI: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], d_req_wdata, d_req_wstrb);
                MSIP: begin
                    if (d_req_wstrb[0]) begin
                        msip_d = d_req_wdata[0];
                    end
                end
                default: ;
            endcase
        end
        timer_irq_d = (mtime_q >= mtimecmp_q);
        soft_irq_d  = msip_q;
    end

    // ------------------------------------------------------------ read data
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    always_comb begin
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (i_acc) begin
            i_rdata_d = i_periph ? 32'd0 : mem[i_idx];
        end
        if (d_acc && !d_is_wr) begin
            d_rdata_d = d_periph ? periph_rdata : mem[d_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_q      <= 1'b0;
            timer_irq_q <= 1'b0;
            soft_irq_q  <= 1'b0;
            i_rdata_q   <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            msip_q      <= msip_d;
            timer_irq_q <= timer_irq_d;
            soft_irq_q  <= soft_irq_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign timer_irq = timer_irq_q;
    assign soft_irq  = soft_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_vigna_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_vigna_bus_responder
//  Description : Self-checking bench for vigna_bus_responder. A transaction-
//                level reference model predicts every output each cycle;
//                directed literal checks pin the model to known answers,
//                followed by concurrent randomized traffic on both ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vigna_bus_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_addr  = 32'd0;
    logic        d_valid = 1'b0;
    logic [31:0] d_addr  = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [3:0]  d_wstrb = 4'd0;
    logic        i_ready, d_ready, timer_irq, soft_irq;
    logic [31:0] i_rdata, d_rdata;

    vigna_bus_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .INIT_FILE("")) dut (
        .clk       (clk),
        .resetn    (resetn),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .timer_irq (timer_irq),
        .soft_irq  (soft_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
        end
    endfunction

    // ------------------------------------------------------ reference model
    logic [31:0] m_mem [DEPTH];
    logic [63:0] m_mtime = 64'd0;
    logic [63:0] m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    logic        m_msip  = 1'b0;
    longint      ecount  = 0;
    // Each port: is a request pending, edge it completes on, first edge a new one may be taken
    logic        i_busy = 1'b0, d_busy = 1'b0;
    longint      i_due = 0, i_free = 0, d_due = 0, d_free = 0;
    logic [31:0] i_la = 32'd0, d_la = 32'd0, d_lw = 32'd0;
    logic [3:0]  d_ls = 4'd0;
    logic        e_i_ready = 1'b0, e_d_ready = 1'b0, e_tirq = 1'b0, e_sirq = 1'b0;
    logic [31:0] e_i_rdata = 32'd0, e_d_rdata = 32'd0;
    logic [63:0] mt_old, cmp_old;
    logic        ms_old, i_com, d_com, mt_wr;

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) & (DEPTH - 1);
    endfunction

    function automatic logic is_per(input logic [31:0] a);
        return a[31:28] == 4'hF;
    endfunction

    function automatic logic [31:0] per_read(input logic [31:0] a);
        case (a[7:2])
            6'd0:    return m_mtime[31:0];
            6'd1:    return m_mtime[63:32];
            6'd2:    return m_cmp[31:0];
            6'd3:    return m_cmp[63:32];
            6'd4:    return {31'd0, m_msip};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_busy = 1'b0; d_busy = 1'b0; i_free = 0; d_free = 0;
            m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_msip = 1'b0;
            e_i_ready = 1'b0; e_d_ready = 1'b0; e_tirq = 1'b0; e_sirq = 1'b0;
            e_i_rdata = 32'd0; e_d_rdata = 32'd0;
        end else begin
            ecount++;
            mt_old = m_mtime; cmp_old = m_cmp; ms_old = m_msip;
            i_com = i_busy && (ecount == i_due);
            d_com = d_busy && (ecount == d_due);
            mt_wr = 1'b0;
            // fetch is resolved first so a same-edge store is not visible to it
            if (i_com) begin
                e_i_rdata = is_per(i_la) ? 32'd0 : m_mem[widx(i_la)];
                i_busy = 1'b0;
            end else if (!i_busy && ecount >= i_free && i_valid) begin
                i_busy = 1'b1; i_due = ecount + LAT; i_free = i_due + 2; i_la = i_addr;
            end
            if (d_com) begin
                d_busy = 1'b0;
                if (d_ls == 4'd0) begin
                    e_d_rdata = is_per(d_la) ? per_read(d_la) : m_mem[widx(d_la)];
                end else if (!is_per(d_la)) begin
                    m_mem[widx(d_la)] = bmerge(m_mem[widx(d_la)], d_lw, d_ls);
                end else begin
                    case (d_la[7:2])
                        6'd0: begin m_mtime[31:0]  = bmerge(m_mtime[31:0], d_lw, d_ls);  mt_wr = 1'b1; end
                        6'd1: begin m_mtime[63:32] = bmerge(m_mtime[63:32], d_lw, d_ls); mt_wr = 1'b1; end
                        6'd2: m_cmp[31:0]  = bmerge(m_cmp[31:0], d_lw, d_ls);
                        6'd3: m_cmp[63:32] = bmerge(m_cmp[63:32], d_lw, d_ls);
                        6'd4: if (d_ls[0]) m_msip = d_lw[0];
                        default: ;
                    endcase
                end
            end else if (!d_busy && ecount >= d_free && d_valid) begin
                d_busy = 1'b1; d_due = ecount + LAT; d_free = d_due + 2;
                d_la = d_addr; d_lw = d_wdata; d_ls = d_wstrb;
            end
            e_i_ready = i_com;
            e_d_ready = d_com;
            if (!mt_wr) m_mtime = m_mtime + 64'd1;
            e_tirq = (mt_old >= cmp_old);
            e_sirq = ms_old;
        end
    end

    // ------------------------------------------------------- compare process
    always @(negedge clk) begin
        chk("i_ready",   32'(i_ready),   32'(e_i_ready));
        chk("d_ready",   32'(d_ready),   32'(e_d_ready));
        chk("i_rdata",   i_rdata,        e_i_rdata);
        chk("d_rdata",   d_rdata,        e_d_rdata);
        chk("timer_irq", 32'(timer_irq), 32'(e_tirq));
        chk("soft_irq",  32'(soft_irq),  32'(e_sirq));
    end

    // ------------------------------------------------------------- drivers
    // Present a request, scramble the bus while it is pending (it must have
    // been latched), and release the bus in the cycle after ready.
    task automatic d_xact(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd, output int waited);
        d_valid = 1'b1; d_addr = a; d_wdata = wd; d_wstrb = st;
        waited = 0; rd = 32'd0;
        while (waited < 40) begin
            @(negedge clk);
            waited++;
            if (d_ready) break;
            d_valid = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_wstrb = 4'($urandom);
        end
        if (d_ready) rd = d_rdata;
        else chk("d_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        d_valid = 1'b0;
    endtask

    task automatic i_xact(input logic [31:0] a, output logic [31:0] rd, output int waited);
        i_valid = 1'b1; i_addr = a;
        waited = 0; rd = 32'd0;
        while (waited < 40) begin
            @(negedge clk);
            waited++;
            if (i_ready) break;
            i_valid = 1'($urandom); i_addr = $urandom;
        end
        if (i_ready) rd = i_rdata;
        else chk("i_ready_timeout", 32'd0, 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 4) == 0) begin
            a = 32'hF000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        end else begin
            a = $urandom;
            if (a[31:28] == 4'hF) a[31:28] = 4'h3;
        end
        return a;
    endfunction

    task automatic rand_d(input int n);
        logic [31:0] rd; int w; logic [3:0] st;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            st = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom);
            d_xact(rand_addr(), $urandom, st, rd, w);
        end
    endtask

    task automatic rand_i(input int n);
        logic [31:0] rd; int w;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            i_xact(rand_addr(), rd, w);
        end
    endtask

    // ------------------------------------------------------------- sequence
    initial begin
        logic [31:0] rd, rdi;
        int w, wi;
        logic got;

        repeat (3) @(negedge clk);
        chk("rst_i_ready", 32'(i_ready), 32'd0);
        chk("rst_d_ready", 32'(d_ready), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_tirq", 32'(timer_irq), 32'd0);
        chk("rst_sirq", 32'(soft_irq), 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        for (int k = 0; k < DEPTH; k++) d_xact(32'(k * 4), $urandom, 4'hF, rd, w);

        // full write, read back, single-byte update
        d_xact(32'h10, 32'hDEAD_BEEF, 4'hF, rd, w);
        chk("wr_latency", 32'(w), 32'(LAT + 1));
        d_xact(32'h10, 32'd0, 4'h0, rd, w);
        chk("rd_deadbeef", rd, 32'hDEAD_BEEF);
        chk("rd_latency", 32'(w), 32'(LAT + 1));
        d_xact(32'h10, 32'h0000_00AA, 4'b0001, rd, w);
        d_xact(32'h10, 32'd0, 4'h0, rd, w);
        chk("rd_byte_merge", rd, 32'hDEAD_BEAA);
        d_xact(32'h113, 32'd0, 4'h0, rd, w);
        chk("rd_alias_wrap", rd, 32'hDEAD_BEAA);

        // fetch with the bus scrambled during the wait
        d_xact(32'h0, 32'h1234_5678, 4'hF, rd, w);
        i_xact(32'h0, rd, w);
        chk("fetch_word0", rd, 32'h1234_5678);
        chk("fetch_latency", 32'(w), 32'(LAT + 1));

        // same-word fetch/store collision
        d_xact(32'hC, 32'h13, 4'hF, rd, w);
        fork
            i_xact(32'hC, rdi, wi);
            d_xact(32'hC, 32'h55, 4'hF, rd, w);
        join
        chk("collision_old", rdi, 32'h13);
        i_xact(32'hC, rdi, wi);
        chk("collision_new", rdi, 32'h55);
        i_xact(32'hF000_0000, rdi, wi);
        chk("fetch_periph", rdi, 32'd0);

        // software interrupt
        d_xact(32'hF000_0010, 32'd1, 4'hF, rd, w);
        chk("soft_irq_set", 32'(soft_irq), 32'd1);
        d_xact(32'hF000_0010, 32'd0, 4'h0, rd, w);
        chk("msip_read", rd, 32'd1);
        d_xact(32'hF000_0013, 32'd0, 4'h0, rd, w);
        chk("msip_read_alias", rd, 32'd1);

        // timer interrupt
        d_xact(32'hF000_0004, 32'd0, 4'hF, rd, w);
        d_xact(32'hF000_0000, 32'd0, 4'hF, rd, w);
        d_xact(32'hF000_000C, 32'd0, 4'hF, rd, w);
        d_xact(32'hF000_0008, 32'd20, 4'hF, rd, w);
        chk("tirq_before", 32'(timer_irq), 32'd0);
        got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (timer_irq) got = 1'b1;
        end
        chk("tirq_rise", 32'(got), 32'd1);
        d_xact(32'hF000_0008, 32'hFFFF_FFFF, 4'hF, rd, w);
        chk("tirq_drop", 32'(timer_irq), 32'd0);

        // reset in the middle of a pending store
        d_xact(32'h14, 32'h0505_0505, 4'hF, rd, w);
        d_xact(32'hF000_0008, 32'd0, 4'hF, rd, w);
        repeat (2) @(negedge clk);
        chk("tirq_pre_reset", 32'(timer_irq), 32'd1);
        d_valid = 1'b1; d_addr = 32'h14; d_wdata = 32'h0000_0BAD; d_wstrb = 4'hF;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_d_ready", 32'(d_ready), 32'd0);
        chk("rst_mid_tirq", 32'(timer_irq), 32'd0);
        chk("rst_mid_sirq", 32'(soft_irq), 32'd0);
        d_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        d_xact(32'h14, 32'd0, 4'h0, rd, w);
        chk("rst_dropped_write", rd, 32'h0505_0505);
        chk("rst_next_latency", 32'(w), 32'(LAT + 1));

        // concurrent random traffic
        fork
            rand_i(300);
            rand_d(300);
        join
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
